// File: rtl/sys_ctrl_pkg.sv
// ============================================================================
//  Module      : sys_ctrl_pkg
//  Description : Command codes, FSM state encoding and fixed operand
//                addresses shared by the command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_ctrl_pkg;

    localparam logic [7:0] c_cmd_reg_wr  = 8'hAA;
    localparam logic [7:0] c_cmd_reg_rd  = 8'hBB;
    localparam logic [7:0] c_cmd_alu_op  = 8'hCC;
    localparam logic [7:0] c_cmd_alu_nop = 8'hDD;

    localparam int unsigned c_op_a_addr = 0;
    localparam int unsigned c_op_b_addr = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FN   = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_LO    = 4'd9,
        ST_TX_HI    = 4'd10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sys_cmd_sequencer_frame_watchdog.sv
// ============================================================================
//  Module      : frame_watchdog
//  Description : Idle-cycle counter; pulses o_timeout after TIMEOUT_CYC
//                unheld cycles without a clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_timeout
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_timeout;

    assign w_timeout = !i_hold && (r_cnt == c_cnt_max);
    assign o_timeout = w_timeout;

    // Self-clearing on expiry so the counter never needs to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_timeout) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_cmd_sequencer.sv
// ============================================================================
//  Module      : sys_cmd_sequencer
//  Description : Decodes RX command frames, drives register file / ALU and
//                pushes response bytes to the TX FIFO, with frame watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_cmd_sequencer
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int ALU_FUN_W   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    output logic                    ALU_EN,
    output logic [ALU_FUN_W-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
    output logic                    FIFO_WR_INC,
    output logic                    BUSY,
    output logic                    FRAME_ERR
);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ALU_FUN_W-1:0]    r_fun;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic                    r_two_byte;

    logic                    r_rf_wr_en;
    logic                    r_rf_rd_en;
    logic [ADDR_WIDTH-1:0]   r_rf_addr;
    logic [DATA_WIDTH-1:0]   r_rf_wr_data;
    logic                    r_alu_en;
    logic [ALU_FUN_W-1:0]    r_alu_fun;
    logic                    r_clk_gate_en;
    logic [DATA_WIDTH-1:0]   r_fifo_data;
    logic                    r_fifo_inc;
    logic                    r_frame_err;

    logic w_take_state;
    logic w_accept;
    logic w_drop;
    logic w_hold;
    logic w_timeout;
    logic w_rescue;
    logic w_abort;

    assign w_take_state = r_state inside {ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                          ST_OP_A, ST_OP_B, ST_ALU_FN};
    assign w_accept     = RX_D_VLD && w_take_state;
    assign w_drop       = RX_D_VLD && !w_take_state;
    assign w_hold       = r_state inside {ST_IDLE, ST_TX_LO, ST_TX_HI};
    // A byte or a result arriving in the expiry cycle takes precedence.
    assign w_rescue     = w_accept
                        || (r_state == ST_RD_WAIT && RF_RdData_VLD)
                        || (r_state == ST_ALU_WAIT && r_alu_en && ALU_OUT_VLD);
    assign w_abort      = w_timeout && !w_rescue;

    frame_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_watchdog (
        .clk       (CLK),
        .rst_n     (RST),
        .i_clr     (w_accept),
        .i_hold    (w_hold),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_fun         <= '0;
            r_result      <= '0;
            r_two_byte    <= 1'b0;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= '0;
            r_clk_gate_en <= 1'b0;
            r_fifo_data   <= '0;
            r_fifo_inc    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rf_wr_en  <= 1'b0;
            r_rf_rd_en  <= 1'b0;
            r_fifo_inc  <= 1'b0;
            r_frame_err <= w_drop || w_abort;

            if (w_abort) begin
                r_state       <= ST_IDLE;
                r_alu_en      <= 1'b0;
                r_clk_gate_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (RX_D_VLD) begin
                        if (RX_P_DATA == DATA_WIDTH'(c_cmd_reg_wr))       r_state <= ST_WR_ADDR;
                        else if (RX_P_DATA == DATA_WIDTH'(c_cmd_reg_rd))  r_state <= ST_RD_ADDR;
                        else if (RX_P_DATA == DATA_WIDTH'(c_cmd_alu_op))  r_state <= ST_OP_A;
                        else if (RX_P_DATA == DATA_WIDTH'(c_cmd_alu_nop)) r_state <= ST_ALU_FN;
                    end
                    ST_WR_ADDR: if (RX_D_VLD) begin
                        r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state <= ST_WR_DATA;
                    end
                    ST_WR_DATA: if (RX_D_VLD) begin
                        r_rf_wr_en   <= 1'b1;
                        r_rf_addr    <= r_addr;
                        r_rf_wr_data <= RX_P_DATA;
                        r_state      <= ST_IDLE;
                    end
                    ST_RD_ADDR: if (RX_D_VLD) begin
                        r_rf_rd_en <= 1'b1;
                        r_rf_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state    <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: if (RF_RdData_VLD) begin
                        r_result   <= {{DATA_WIDTH{1'b0}}, RF_RdData};
                        r_two_byte <= 1'b0;
                        r_state    <= ST_TX_LO;
                    end
                    ST_OP_A: if (RX_D_VLD) begin
                        r_rf_wr_en   <= 1'b1;
                        r_rf_addr    <= ADDR_WIDTH'(c_op_a_addr);
                        r_rf_wr_data <= RX_P_DATA;
                        r_state      <= ST_OP_B;
                    end
                    ST_OP_B: if (RX_D_VLD) begin
                        r_rf_wr_en   <= 1'b1;
                        r_rf_addr    <= ADDR_WIDTH'(c_op_b_addr);
                        r_rf_wr_data <= RX_P_DATA;
                        r_state      <= ST_ALU_FN;
                    end
                    ST_ALU_FN: if (RX_D_VLD) begin
                        r_fun         <= RX_P_DATA[ALU_FUN_W-1:0];
                        r_clk_gate_en <= 1'b1;
                        r_two_byte    <= 1'b1;
                        r_state       <= ST_ALU_WAIT;
                    end
                    // Gate opens one cycle ahead of the enable so the ALU clock is running.
                    ST_ALU_WAIT: begin
                        if (r_alu_en && ALU_OUT_VLD) begin
                            r_result      <= ALU_OUT;
                            r_alu_en      <= 1'b0;
                            r_clk_gate_en <= 1'b0;
                            r_state       <= ST_TX_LO;
                        end else if (!r_alu_en) begin
                            r_alu_en  <= 1'b1;
                            r_alu_fun <= r_fun;
                        end
                    end
                    ST_TX_LO: if (!FIFO_FULL) begin
                        r_fifo_inc  <= 1'b1;
                        r_fifo_data <= r_result[DATA_WIDTH-1:0];
                        r_state     <= r_two_byte ? ST_TX_HI : ST_IDLE;
                    end
                    ST_TX_HI: if (!FIFO_FULL) begin
                        r_fifo_inc  <= 1'b1;
                        r_fifo_data <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_state     <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign RF_WrEn      = r_rf_wr_en;
    assign RF_RdEn      = r_rf_rd_en;
    assign RF_Address   = r_rf_addr;
    assign RF_WrData    = r_rf_wr_data;
    assign ALU_EN       = r_alu_en;
    assign ALU_FUN      = r_alu_fun;
    assign CLK_GATE_EN  = r_clk_gate_en;
    assign FIFO_WR_DATA = r_fifo_data;
    assign FIFO_WR_INC  = r_fifo_inc;
    assign BUSY         = (r_state != ST_IDLE);
    assign FRAME_ERR    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_sys_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_sys_cmd_sequencer
//  Description : Directed self-checking bench for sys_cmd_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sys_cmd_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic [DW-1:0] RF_RdData = '0;
    logic          RF_RdData_VLD = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic          ALU_OUT_VLD = 1'b0;
    logic          FIFO_FULL = 1'b0;
    logic          RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, FIFO_WR_INC, BUSY, FRAME_ERR;
    logic [AW-1:0] RF_Address;
    logic [DW-1:0] RF_WrData, FIFO_WR_DATA;
    logic [FW-1:0] ALU_FUN;

    always #5 CLK = ~CLK;

    sys_cmd_sequencer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ALU_FUN_W (FW), .TIMEOUT_CYC (TO)
    ) dut (
        .CLK (CLK), .RST (RST), .RX_P_DATA (RX_P_DATA), .RX_D_VLD (RX_D_VLD),
        .RF_RdData (RF_RdData), .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_OUT (ALU_OUT), .ALU_OUT_VLD (ALU_OUT_VLD), .FIFO_FULL (FIFO_FULL),
        .RF_WrEn (RF_WrEn), .RF_RdEn (RF_RdEn), .RF_Address (RF_Address),
        .RF_WrData (RF_WrData), .ALU_EN (ALU_EN), .ALU_FUN (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN), .FIFO_WR_DATA (FIFO_WR_DATA),
        .FIFO_WR_INC (FIFO_WR_INC), .BUSY (BUSY), .FRAME_ERR (FRAME_ERR)
    );

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] wr_log[$];
    logic [DW-1:0]    fifo_log[$];
    int err_cnt  = 0;
    int gate_cnt = 0;

    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WrEn)     wr_log.push_back({RF_Address, RF_WrData});
            if (FIFO_WR_INC) fifo_log.push_back(FIFO_WR_DATA);
            if (FRAME_ERR)   err_cnt++;
            if (CLK_GATE_EN) gate_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fifo_at(input int i);
        return (i < fifo_log.size()) ? {24'h0, fifo_log[i]} : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wr_at(input int i);
        return (i < wr_log.size()) ? {20'h0, wr_log[i]} : 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_alu_en(input string tag);
        int n = 0;
        while (!ALU_EN && n < 50) begin
            tick(1);
            n++;
        end
        check(tag, {31'h0, ALU_EN}, 32'd1);
    endtask

    task automatic alu_result(input logic [2*DW-1:0] r, input logic full);
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        FIFO_FULL   = full;
        tick(1);
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = '0;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, FIFO_WR_DATA, FIFO_WR_INC, BUSY, FRAME_ERR};
    endfunction

    initial begin
        int e0;
        #12 RST = 1'b1;
        tick(1);
        check("reset_outs", all_outs(), 32'h0);

        // 1: register write
        send_byte(8'hAA); send_byte(8'h05);
        check("wr_busy_mid", {31'h0, BUSY}, 32'd1);
        check("wr_no_early", {31'h0, RF_WrEn}, 32'd0);
        send_byte(8'h3C);
        check("wr_en", {31'h0, RF_WrEn}, 32'd1);
        check("wr_addr", {28'h0, RF_Address}, 32'h5);
        check("wr_data", {24'h0, RF_WrData}, 32'h3C);
        check("wr_busy_fall", {31'h0, BUSY}, 32'd0);
        tick(1);
        check("wr_one_cycle", {31'h0, RF_WrEn}, 32'd0);

        // 2: register read
        fifo_log.delete();
        send_byte(8'hBB); send_byte(8'h05);
        check("rd_en", {31'h0, RF_RdEn}, 32'd1);
        check("rd_addr", {28'h0, RF_Address}, 32'h5);
        tick(1);
        RF_RdData = 8'h3C; RF_RdData_VLD = 1'b1;
        tick(1);
        RF_RdData_VLD = 1'b0;
        tick(3);
        check("rd_push_n", fifo_log.size(), 32'd1);
        check("rd_push0", fifo_at(0), 32'h3C);
        check("rd_idle", {31'h0, BUSY}, 32'd0);

        // 3: ALU with operands
        fifo_log.delete(); wr_log.delete(); gate_cnt = 0;
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03);
        check("alu_gate_pre", gate_cnt, 32'd0);
        send_byte(8'h00);
        check("alu_gate_on", {31'h0, CLK_GATE_EN}, 32'd1);
        check("alu_en_late", {31'h0, ALU_EN}, 32'd0);
        tick(1);
        check("alu_en_on", {31'h0, ALU_EN}, 32'd1);
        check("alu_fun0", {28'h0, ALU_FUN}, 32'h0);
        alu_result(16'h000A, 1'b0);
        check("alu_drop", {30'h0, CLK_GATE_EN, ALU_EN}, 32'd0);
        tick(3);
        check("alu_gate_cyc", gate_cnt, 32'd2);
        check("alu_opa", wr_at(0), 32'h007);
        check("alu_opb", wr_at(1), 32'h103);
        check("alu_push_n", fifo_log.size(), 32'd2);
        check("alu_push_lo", fifo_at(0), 32'h0A);
        check("alu_push_hi", fifo_at(1), 32'h00);

        // 4: FIFO back-pressure longer than the watchdog period
        fifo_log.delete(); e0 = err_cnt;
        send_byte(8'hDD); send_byte(8'h02);
        wait_alu_en("full_alu_en");
        check("full_fun", {28'h0, ALU_FUN}, 32'h2);
        alu_result(16'h1234, 1'b1);
        tick(19);
        check("full_no_push", fifo_log.size(), 32'd0);
        check("full_busy", {31'h0, BUSY}, 32'd1);
        FIFO_FULL = 1'b0;
        tick(4);
        check("full_push_n", fifo_log.size(), 32'd2);
        check("full_push_lo", fifo_at(0), 32'h34);
        check("full_push_hi", fifo_at(1), 32'h12);
        check("full_no_err", err_cnt - e0, 32'd0);

        // 5: watchdog abort mid-frame
        wr_log.delete(); fifo_log.delete(); e0 = err_cnt;
        send_byte(8'hAA); send_byte(8'h05);
        tick(15);
        check("to_busy_edge", {31'h0, BUSY}, 32'd1);
        tick(1);
        check("to_idle", {31'h0, BUSY}, 32'd0);
        check("to_err_pulse", {31'h0, FRAME_ERR}, 32'd1);
        tick(3);
        check("to_err_n", err_cnt - e0, 32'd1);
        check("to_no_wr", wr_log.size(), 32'd0);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        tick(1);
        check("to_recover", wr_at(0), 32'h1FF);

        // 6: ignored byte, dropped byte in ALU_WAIT, reset mid-frame
        fifo_log.delete(); e0 = err_cnt;
        send_byte(8'h55);
        check("junk_idle", {31'h0, BUSY}, 32'd0);
        send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
        wait_alu_en("drop_alu_en");
        send_byte(8'h99);
        alu_result(16'hBEEF, 1'b0);
        tick(4);
        check("drop_err_n", err_cnt - e0, 32'd1);
        check("drop_push_lo", fifo_at(0), 32'hEF);
        check("drop_push_hi", fifo_at(1), 32'hBE);

        send_byte(8'hCC); send_byte(8'h44);
        check("rst_pre", {31'h0, RF_WrEn}, 32'd1);
        RST = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
